// File: rtl/uart_tx_if.sv
// Producer-side handshake bundle for uart_tx_frame.
// Parity control ports exist only when UART_TX_PARITY_EN is defined.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 txd;
  logic                 tx_busy;
  logic                 tx_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_en;
  logic                 par_odd;
`endif

  modport master (
    output tx_data, tx_valid,
`ifdef UART_TX_PARITY_EN
    output par_en, par_odd,
`endif
    input  tx_ready, txd, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
`ifdef UART_TX_PARITY_EN
    input  par_en, par_odd,
`endif
    output tx_ready, txd, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start / DATA_BITS LSB-first / [parity] / STOP_BITS stop.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | sending start bit (low)
// DATA   | shifting out data bits, LSB first
// PARITY | sending latched parity bit (UART_TX_PARITY_EN only)
// STOP   | sending STOP_BITS high bits, then pulse tx_done
module uart_tx_frame #(
  parameter logic [15:0] CLK_DIV   = 16'd434,
  parameter int          DATA_BITS = 8,
  parameter int          STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     n_rst,
  uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] LAST_CNT  = CLK_DIV - 16'd1;
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  state_t               state, state_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 txd_q, txd_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_en_nxt;
  logic                 par_bit_q, par_bit_nxt;
`endif

  assign bus.tx_ready = (state == IDLE);
  assign bus.txd      = txd_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

  assign bit_tick = (state != IDLE) && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      txd_q     <= txd_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_nxt;
      par_bit_q <= par_bit_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (state == IDLE || bit_tick) ? 16'd0 : cnt + 16'd1;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    txd_nxt     = txd_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit_q;
`endif
    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          shreg_nxt   = bus.tx_data;
          txd_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = START;
`ifdef UART_TX_PARITY_EN
          par_en_nxt  = bus.par_en;
          par_bit_nxt = bus.par_odd ? ~^bus.tx_data : ^bus.tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          txd_nxt   = shreg[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              txd_nxt   = par_bit_q;
              state_nxt = PARITY;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = STOP;
            end
`else
            txd_nxt   = 1'b1;
            state_nxt = STOP;
`endif
          end else begin
            // next bit goes out as the register shifts
            shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
            txd_nxt     = shreg[1];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          txd_nxt   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_nxt = '0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with CLK_DIV=4; instance a is 8N1, instance b is 5 data / 2 stop.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_frame;
  logic clk;
  logic n_rst;
  int   n_run;
  int   n_fail;

  uart_tx_if #(.DATA_BITS(8)) if_a ();
  uart_tx_if #(.DATA_BITS(5)) if_b ();

  uart_tx_frame #(.CLK_DIV(16'd4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (if_a.slave)
  );

  uart_tx_frame #(.CLK_DIV(16'd4), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (if_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // bits[j] is the j-th bit on the line, start bit first
  task automatic frame_a(input string tag, input logic [7:0] d, input logic [15:0] bits,
                         input int nbits, input bit noise);
    int k;
    int len;
    len = 4 * nbits;
    k = 0;
    while (!if_a.tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready_wait"}, 32'(if_a.tx_ready), 32'd1);
    @(negedge clk);
    if_a.tx_data  = d;
    if_a.tx_valid = 1'b1;
    @(posedge clk);
    for (int s = 0; s <= len + 1; s++) begin
      @(negedge clk);
      if (noise && s < len - 4) begin
        if_a.tx_data  = 8'(s * 29 + 7);
        if_a.tx_valid = s[0];
      end else begin
        if_a.tx_valid = 1'b0;
      end
      if (s < len)
        check({tag, "_txd"}, 32'(if_a.txd), 32'(bits[s/4]));
      check({tag, "_busy"},  32'(if_a.tx_busy),  32'(s < len));
      check({tag, "_ready"}, 32'(if_a.tx_ready), 32'(s >= len));
      check({tag, "_done"},  32'(if_a.tx_done),  32'(s == len));
    end
  endtask

  initial begin
    int  falls;
    int  fall_t[2];
    int  dones;
    logic prev;

    n_run  = 0;
    n_fail = 0;
    n_rst  = 1'b0;
    if_a.tx_data  = '0;
    if_a.tx_valid = 1'b0;
    if_b.tx_data  = '0;
    if_b.tx_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    if_a.par_en  = 1'b0;
    if_a.par_odd = 1'b0;
    if_b.par_en  = 1'b0;
    if_b.par_odd = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_txd",   32'(if_a.txd),      32'd1);
    check("rst_busy",  32'(if_a.tx_busy),  32'd0);
    check("rst_done",  32'(if_a.tx_done),  32'd0);
    check("rst_ready", 32'(if_a.tx_ready), 32'd1);
    check("rst_b_txd", 32'(if_b.txd),      32'd1);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 8'hA5 -> 0,1,0,1,0,0,1,0,1,1
    frame_a("t1", 8'hA5, 16'h034A, 10, 1'b0);

    // 2: back-to-back with tx_valid held high
    @(negedge clk);
    if_a.tx_data  = 8'h00;
    if_a.tx_valid = 1'b1;
    prev  = if_a.txd;
    falls = 0;
    dones = 0;
    fall_t[0] = -1;
    fall_t[1] = -1;
    @(posedge clk);
    for (int s = 0; s < 90; s++) begin
      @(negedge clk);
      if (s == 0) if_a.tx_data = 8'hFF;
      if (s == 41) if_a.tx_valid = 1'b0;
      if (prev && !if_a.txd) begin
        if (falls < 2) fall_t[falls] = s;
        falls++;
      end
      prev = if_a.txd;
      if (if_a.tx_done) dones++;
      if (s == 17) check("t2_bit_00", 32'(if_a.txd), 32'd0);
      if (s == 61) check("t2_bit_ff", 32'(if_a.txd), 32'd1);
    end
    check("t2_falls",   32'(falls), 32'd2);
    check("t2_first",   32'(fall_t[0]), 32'd0);
    check("t2_pitch",   32'(fall_t[1] - fall_t[0]), 32'd41);
    check("t2_dones",   32'(dones), 32'd2);

`ifdef UART_TX_PARITY_EN
    // 3: parity on 8'h07 (three ones)
    if_a.par_en = 1'b1; if_a.par_odd = 1'b0;
    frame_a("t3_even", 8'h07, 16'h060E, 11, 1'b0);
    if_a.par_en = 1'b1; if_a.par_odd = 1'b1;
    frame_a("t3_odd",  8'h07, 16'h040E, 11, 1'b0);
    if_a.par_en = 1'b0; if_a.par_odd = 1'b0;
    frame_a("t3_off",  8'h07, 16'h020E, 10, 1'b0);
`endif

    // 4: 5 data bits, 2 stop bits: 8 bits of 4 cycles, done 32 cycles after accept
    @(negedge clk);
    if_b.tx_data  = 5'h1F;
    if_b.tx_valid = 1'b1;
    @(posedge clk);
    for (int s = 0; s < 36; s++) begin
      @(negedge clk);
      if_b.tx_valid = 1'b0;
      if (s < 32) check("t4_txd", 32'(if_b.txd), 32'(s >= 4));
      check("t4_ready", 32'(if_b.tx_ready), 32'(s >= 32));
      check("t4_done",  32'(if_b.tx_done),  32'(s == 32));
    end

    // 5: reset mid-frame
    @(negedge clk);
    if_a.tx_data  = 8'h55;
    if_a.tx_valid = 1'b1;
    @(posedge clk);
    for (int s = 0; s < 13; s++) begin
      @(negedge clk);
      if_a.tx_valid = 1'b0;
    end
    check("t5_pre_busy", 32'(if_a.tx_busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("t5_txd",   32'(if_a.txd),      32'd1);
    check("t5_busy",  32'(if_a.tx_busy),  32'd0);
    check("t5_ready", 32'(if_a.tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    for (int s = 0; s < 45; s++) begin
      @(negedge clk);
      if (if_a.tx_done) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);
    frame_a("t5_after", 8'h3C, 16'h0278, 10, 1'b0);

    // 6: data and valid noise while busy
    frame_a("t6", 8'hC3, 16'h0386, 10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
